// File: rtl/fsm_lat_input_cond_pkg.sv
// Shared definitions for the FSM_LAT input-conditioning stage.
// Holds the load FSM state encoding and the default parameter values used
// by the top level and the per-line debouncer.
package fsm_lat_input_cond_pkg;

  // Code 2'd3 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_HOLD   = 2'd2
  } load_state_t;

  localparam int DEF_WIDTH           = 5;
  localparam int DEF_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/fsm_lat_input_cond_debounce_line.sv
// debounce_line: conditions one asynchronous pad line.
// A 2-flop synchroniser feeds a run-length counter; the debounced value only
// follows the synchronised line after DEBOUNCE_CYCLES consecutive samples that
// differ from the current debounced value.
// Ports:
//   clk_in  - system clock
//   reset   - asynchronous active-low reset
//   raw     - raw pad input (asynchronous)
//   deb     - debounced, registered output
module debounce_line
  import fsm_lat_input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk_in,
  input  logic reset,
  input  logic raw,
  output logic deb
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  // Stage p0/p1: two-flop synchroniser
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce stage: any sample equal to deb discards the partial count
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      deb <= 1'b0;
    end else if (sync_p1 == deb) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      deb <= sync_p1;
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fsm_lat_input_cond.sv
// fsm_lat_input_cond: input conditioning in front of FSM_LAT.
// Synchronises and debounces WIDTH data switches plus a load button, then
// emits a one-cycle reg_state strobe per accepted press together with a data
// snapshot (in_q) that only changes on that strobe.
// Ports:
//   clk_in    - system clock
//   reset     - asynchronous active-low reset
//   raw_in    - raw data switches [WIDTH-1:0]
//   raw_load  - raw load button, active-high
//   in_q      - debounced data snapshot, updated when the strobe begins
//   reg_state - one-cycle load strobe (registered)
//   load_held - high while the accepted press is still held
module fsm_lat_input_cond
  import fsm_lat_input_cond_pkg::*;
#(
  parameter int WIDTH           = DEF_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  input  logic             raw_load,
  output logic [WIDTH-1:0] in_q,
  output logic             reg_state,
  output logic             load_held
);

  logic [WIDTH-1:0] deb_data;
  logic             deb_load;
  load_state_t      state;
  load_state_t      state_nx;

  // Debounce stage: one conditioner per data line and one for the button
  for (genvar i = 0; i < WIDTH; i++) begin : g_data
    debounce_line #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk_in (clk_in),
      .reset  (reset),
      .raw    (raw_in[i]),
      .deb    (deb_data[i])
    );
  end

  debounce_line #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_load (
    .clk_in (clk_in),
    .reset  (reset),
    .raw    (raw_load),
    .deb    (deb_load)
  );

  // Load FSM stage: state register
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = ST_IDLE;
    case (state)
      ST_IDLE:   state_nx = deb_load ? ST_STROBE : ST_IDLE;
      ST_STROBE: state_nx = ST_HOLD;
      ST_HOLD:   state_nx = deb_load ? ST_HOLD : ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Output stage: outputs are decoded from state_nx and registered so they
  // are glitch-free and aligned with the state they describe. in_q captures
  // the registered deb_data, so a data word accepted on the same edge that
  // enters STROBE is not seen until the next press.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      reg_state <= 1'b0;
      load_held <= 1'b0;
      in_q      <= '0;
    end else begin
      reg_state <= (state_nx == ST_STROBE);
      load_held <= (state_nx == ST_HOLD);
      if (state_nx == ST_STROBE) begin
        in_q <= deb_data;
      end
    end
  end

endmodule

// File: tb/tb_fsm_lat_input_cond.sv
// Bench for fsm_lat_input_cond with DEBOUNCE_CYCLES = 4.
// Stimulus pushes the expected strobe (edge number and data word) into a
// scoreboard queue; a monitor pops and compares whenever reg_state is high.
module tb_fsm_lat_input_cond;

  localparam int W = 5;
  localparam int D = 4;
  localparam int LAT = D + 3;

  logic         clk_in;
  logic         reset;
  logic [W-1:0] raw_in;
  logic         raw_load;
  logic [W-1:0] in_q;
  logic         reg_state;
  logic         load_held;

  typedef struct {
    int           cyc;
    logic [W-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  logic prev_rs = 1'b0;

  fsm_lat_input_cond #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .raw_in    (raw_in),
    .raw_load  (raw_load),
    .in_q      (in_q),
    .reg_state (reg_state),
    .load_held (load_held)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic expect_strobe(input logic [W-1:0] data);
    exp_t e;
    e.cyc  = cyc + LAT;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic press(input logic [W-1:0] data);
    raw_load = 1'b1;
    expect_strobe(data);
  endtask

  // Release the button and check load_held falls exactly LAT edges later.
  task automatic release_load();
    raw_load = 1'b0;
    step(LAT - 1);
    chk("load_held_before_fall", int'(load_held), 1);
    step(1);
    chk("load_held_after_fall", int'(load_held), 0);
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk_in) begin
    if (reg_state) begin
      chk("strobe_one_cycle", int'(prev_rs), 0);
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("strobe_edge", cyc, e.cyc);
        chk("strobe_in_q", int'(in_q), int'(e.data));
      end
    end
    prev_rs = reg_state;
  end

  initial begin
    // Reset with inputs already active
    reset    = 1'b0;
    raw_in   = 5'b10101;
    raw_load = 1'b1;
    step(3);
    chk("rst_in_q", int'(in_q), 0);
    chk("rst_reg_state", int'(reg_state), 0);
    chk("rst_load_held", int'(load_held), 0);
    step(3);
    chk("rst_in_q_late", int'(in_q), 0);
    chk("rst_reg_state_late", int'(reg_state), 0);
    chk("rst_load_held_late", int'(load_held), 0);
    reset = 1'b1;
    expect_strobe(5'b10101);
    step(12);
    chk("rst_hold_in_q", int'(in_q), 32'h15);
    release_load();

    // Basic load
    raw_in = 5'b01101;
    step(10);
    press(5'b01101);
    step(20);
    chk("basic_in_q", int'(in_q), 32'h0d);
    chk("basic_load_held", int'(load_held), 1);
    release_load();

    // Glitch rejection: D-1 cycle load pulse and 2-cycle data toggle
    step(5);
    raw_load = 1'b1;
    step(D - 1);
    raw_load = 1'b0;
    step(10);
    raw_in = 5'b01100;
    step(2);
    raw_in = 5'b01101;
    step(12);
    chk("glitch_in_q", int'(in_q), 32'h0d);
    chk("glitch_load_held", int'(load_held), 0);

    // Data change while held
    raw_in = 5'b00011;
    step(10);
    press(5'b00011);
    step(10);
    raw_in = 5'b11100;
    step(10);
    chk("held_change_in_q", int'(in_q), 32'h03);
    release_load();
    step(3);
    press(5'b11100);
    step(10);
    release_load();

    // Bouncy press, then stable hold
    step(3);
    for (int i = 0; i < 6; i++) begin
      raw_load = (i % 2 == 0);
      step(1);
    end
    press(5'b11100);
    step(12);
    release_load();

    // Data accepted on the very edge that enters STROBE: old word is taken
    step(3);
    press(5'b11100);
    step(1);
    raw_in = 5'b00110;
    step(12);
    chk("same_edge_in_q_kept", int'(in_q), 32'h1c);
    release_load();

    // Reset during HOLD, button still held afterwards
    raw_in = 5'b01010;
    step(10);
    press(5'b01010);
    step(12);
    chk("pre_reset_load_held", int'(load_held), 1);
    chk("pre_reset_in_q", int'(in_q), 32'h0a);
    #1;
    reset = 1'b0;
    #1;
    chk("async_rst_in_q", int'(in_q), 0);
    chk("async_rst_reg_state", int'(reg_state), 0);
    chk("async_rst_load_held", int'(load_held), 0);
    step(3);
    reset = 1'b1;
    expect_strobe(5'b01010);
    step(12);
    release_load();

    step(5);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, edge %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
